// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : div_unit
//  Description : Iterative radix-2 restoring divider for MIPS DIV/DIVU in the
//                execute stage. Raises div_stall while a divide occupies E and
//                drops it for the cycle the registered result becomes valid.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              div_en,
    input  logic              div_signed,
    input  logic [DATA_W-1:0] opaE,
    input  logic [DATA_W-1:0] opbE,
    input  logic              ext_stall,
    input  logic              flushE,
    output logic              div_stall,
    output logic              div_done,
    output logic [DATA_W-1:0] hi_out,
    output logic [DATA_W-1:0] lo_out
);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_busy   = 2'd1;
    localparam logic [1:0] c_st_done   = 2'd2;
    localparam logic [5:0] c_last_iter = 6'(DATA_W - 1);

    logic [1:0]        r_state;
    logic [5:0]        r_cnt;
    logic [DATA_W-1:0] r_dvd;      // dividend bits shift out, quotient bits shift in
    logic [DATA_W-1:0] r_dvs;      // |divisor|
    logic [DATA_W:0]   r_rem;      // partial remainder
    logic              r_q_neg;
    logic              r_r_neg;

    logic              w_a_neg;
    logic              w_b_neg;
    logic [DATA_W-1:0] w_a_abs;
    logic [DATA_W-1:0] w_b_abs;
    logic [DATA_W+1:0] w_shift;
    logic [DATA_W+1:0] w_trial;
    logic              w_fits;
    logic [DATA_W:0]   w_rem_nxt;
    logic [DATA_W-1:0] w_dvd_nxt;
    logic [DATA_W-1:0] w_quo_fix;
    logic [DATA_W-1:0] w_rem_fix;

    // Operand signs only matter for DIV; DIVU treats both as magnitudes.
    assign w_a_neg = div_signed & opaE[DATA_W-1];
    assign w_b_neg = div_signed & opbE[DATA_W-1];
    assign w_a_abs = w_a_neg ? -opaE : opaE;
    assign w_b_abs = w_b_neg ? -opbE : opbE;

    // One restoring step. The trial is two bits wider than the divisor so the
    // borrow bit is an unambiguous sign even when the shifted remainder
    // reaches 2^DATA_W (large divisors).
    assign w_shift   = {r_rem, r_dvd[DATA_W-1]};
    assign w_trial   = w_shift - {2'b00, r_dvs};
    assign w_fits    = ~w_trial[DATA_W+1];
    assign w_rem_nxt = w_fits ? w_trial[DATA_W:0] : w_shift[DATA_W:0];
    assign w_dvd_nxt = {r_dvd[DATA_W-2:0], w_fits};

    // Sign fixups applied to the final step's result as it is registered.
    assign w_quo_fix = r_q_neg ? -w_dvd_nxt : w_dvd_nxt;
    assign w_rem_fix = r_r_neg ? -w_rem_nxt[DATA_W-1:0] : w_rem_nxt[DATA_W-1:0];

    // Stall is released in DONE so the instruction can leave E, and never
    // asserted while E is being flushed.
    assign div_stall = div_en & (r_state != c_st_done) & ~flushE;
    assign div_done  = (r_state == c_st_done);

    // Control FSM, iteration datapath and result registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= c_st_idle;
            r_cnt   <= 6'd0;
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_rem   <= '0;
            r_q_neg <= 1'b0;
            r_r_neg <= 1'b0;
            hi_out  <= '0;
            lo_out  <= '0;
        end else if (flushE) begin
            // Abort wins over everything, results stay untouched.
            r_state <= c_st_idle;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (div_en) begin
                        r_dvd   <= w_a_abs;
                        r_dvs   <= w_b_abs;
                        r_rem   <= '0;
                        r_q_neg <= w_a_neg ^ w_b_neg;
                        r_r_neg <= w_a_neg;
                        r_cnt   <= 6'd0;
                        r_state <= c_st_busy;
                    end
                end
                c_st_busy: begin
                    r_rem <= w_rem_nxt;
                    r_dvd <= w_dvd_nxt;
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == c_last_iter) begin
                        lo_out  <= w_quo_fix;
                        hi_out  <= w_rem_fix;
                        r_state <= c_st_done;
                    end
                end
                c_st_done: begin
                    // Hold the result while something else freezes E.
                    if (!ext_stall) begin
                        r_state <= c_st_idle;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_unit
//  Description : Self-checking bench for div_unit. Stimulus pushes expected
//                results into a queue; a monitor pops them on each new result.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_div_unit;

    localparam int W = 32;

    logic         clk        = 1'b0;
    logic         resetn     = 1'b0;
    logic         div_en     = 1'b0;
    logic         div_signed = 1'b0;
    logic [W-1:0] opaE       = '0;
    logic [W-1:0] opbE       = '0;
    logic         ext_stall  = 1'b0;
    logic         flushE     = 1'b0;
    logic         div_stall;
    logic         div_done;
    logic [W-1:0] hi_out;
    logic [W-1:0] lo_out;

    int checks   = 0;
    int failures = 0;

    logic [2*W-1:0] exp_q[$];
    logic           prev_done = 1'b0;

    div_unit #(.DATA_W(W)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .div_en     (div_en),
        .div_signed (div_signed),
        .opaE       (opaE),
        .opbE       (opbE),
        .ext_stall  (ext_stall),
        .flushE     (flushE),
        .div_stall  (div_stall),
        .div_done   (div_done),
        .hi_out     (hi_out),
        .lo_out     (lo_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: compare each new result against the oldest expected entry.
    always @(negedge clk) begin
        logic [2*W-1:0] e;
        if (!resetn) begin
            prev_done = 1'b0;
        end else begin
            if (div_done && !prev_done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result: got lo=0x%08h hi=0x%08h expected no result", lo_out, hi_out);
                end else begin
                    e = exp_q.pop_front();
                    check("result_lo", lo_out, e[2*W-1:W]);
                    check("result_hi", hi_out, e[W-1:0]);
                end
            end
            prev_done = div_done;
        end
    end

    // One full divide: counts stall cycles, optionally holds ext_stall
    // for four cycles from DONE entry, then lets the instruction leave E.
    task automatic run_div(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] exp_lo, input logic [W-1:0] exp_hi,
                           input logic use_ext);
        int n;
        exp_q.push_back({exp_lo, exp_hi});
        @(posedge clk); #1;
        div_en = 1'b1; div_signed = s; opaE = a; opbE = b;
        n = 0;
        @(negedge clk);
        while (div_stall && n < 100) begin
            n++;
            if (n == 5) begin
                opaE = ~a; opbE = b ^ 32'h0000_0055; div_signed = ~s;
            end
            @(negedge clk);
        end
        check("stall_cycles", 32'(n), 32'd33);
        check("done_at_33", 32'(div_done), 32'd1);
        if (use_ext) begin
            ext_stall = 1'b1;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                check("ext_hold_done", 32'(div_done), 32'd1);
                check("ext_hold_stall", 32'(div_stall), 32'd0);
                check("ext_hold_lo", lo_out, exp_lo);
                check("ext_hold_hi", hi_out, exp_hi);
            end
            @(posedge clk); #1;
            ext_stall = 1'b0;
            @(negedge clk);
            check("ext_release_done", 32'(div_done), 32'd1);
        end
        @(posedge clk); #1;
        div_en = 1'b0;
        @(negedge clk);
        check("idle_after_done", 32'(div_done), 32'd0);
        check("idle_stall", 32'(div_stall), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_lo", lo_out, 32'd0);
        check("reset_hi", hi_out, 32'd0);
        check("reset_done", 32'(div_done), 32'd0);
        check("reset_stall", 32'(div_stall), 32'd0);
        @(posedge clk); #1;
        resetn = 1'b1;

        run_div(1'b0, 32'd100,        32'd7,          32'h0000_000E, 32'h0000_0002, 1'b0);
        run_div(1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b1);
        run_div(1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD, 32'h0000_0001, 1'b0);
        run_div(1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 32'h0000_0000, 1'b0);
        run_div(1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF, 32'h0000_0005, 1'b0);
        run_div(1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'h0000_0001, 32'h0000_0001, 1'b0);
        run_div(1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'h0000_000E, 32'hFFFF_FFFE, 1'b0);
        run_div(1'b1, 32'hFFFF_FFFB,  32'd0,          32'h0000_0001, 32'hFFFF_FFFB, 1'b0);
        run_div(1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000, 32'h8000_0000, 1'b0);

        // Flush at BUSY cycle 10: no result, previous hi/lo retained.
        @(posedge clk); #1;
        div_en = 1'b1; div_signed = 1'b0; opaE = 32'd1000; opbE = 32'd10;
        repeat (10) @(posedge clk);
        #1;
        flushE = 1'b1;
        @(negedge clk);
        check("flush_stall", 32'(div_stall), 32'd0);
        @(posedge clk); #1;
        flushE = 1'b0; div_en = 1'b0;
        @(negedge clk);
        check("flush_idle_done", 32'(div_done), 32'd0);
        check("flush_keep_lo", lo_out, 32'h0000_0000);
        check("flush_keep_hi", hi_out, 32'h8000_0000);
        repeat (40) @(negedge clk);
        check("flush_no_result", 32'(div_done), 32'd0);
        run_div(1'b0, 32'd9, 32'd3, 32'h0000_0003, 32'h0000_0000, 1'b0);

        // Reset at BUSY cycle 20 clears outputs immediately.
        @(posedge clk); #1;
        div_en = 1'b1; div_signed = 1'b0; opaE = 32'd100; opbE = 32'd7;
        repeat (20) @(posedge clk);
        #1;
        resetn = 1'b0; div_en = 1'b0;
        #1;
        check("midreset_lo", lo_out, 32'd0);
        check("midreset_hi", hi_out, 32'd0);
        check("midreset_done", 32'(div_done), 32'd0);
        check("midreset_stall", 32'(div_stall), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        run_div(1'b0, 32'd100, 32'd7, 32'h0000_000E, 32'h0000_0002, 1'b0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
